// File: rtl/scsi_pkg.sv
// ============================================================================
// Module   : scsi_pkg
// Brief    : Shared types and constants for the SCSI io-controller arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package scsi_pkg;

  // Width of a target index on the host side (covers up to 8 targets).
  localparam int DEV_IDX_W = 3;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } state_t;

  // Committed block operation for the current grant.
  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

endpackage

`default_nettype wire

// File: rtl/scsi_rr_pick.sv
// ============================================================================
// Module   : scsi_rr_pick
// Brief    : Combinational round-robin picker. Returns the first set request
//            bit at or after i_ptr, wrapping modulo DEVS.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module scsi_rr_pick
  import scsi_pkg::*;
#(
  parameter int DEVS = 2
) (
  input  logic [DEVS-1:0]      i_req,
  input  logic [DEV_IDX_W-1:0] i_ptr,
  output logic [DEV_IDX_W-1:0] o_idx,
  output logic                 o_valid
);

  int w_cand;

  // Walk candidates starting at the pointer; the first pending one wins.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = 0;
    for (int k = 0; k < DEVS; k++) begin
      w_cand = int'(i_ptr) + k;
      if (w_cand >= DEVS) w_cand = w_cand - DEVS;
      for (int i = 0; i < DEVS; i++) begin
        if (!o_valid && (i == w_cand) && i_req[i]) begin
          o_valid = 1'b1;
          o_idx   = DEV_IDX_W'(i);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/scsi_io_arb.sv
// ============================================================================
// Module   : scsi_io_arb
// Brief    : Round-robin arbiter sharing one io-controller sector port between
//            DEVS SCSI targets. Steers ack, buffer strobe and write data to the
//            granted target only.
//            Optional macro SCSI_ARB_TMO_EN adds a REQ/XFER watchdog
//            (TMO_CYCLES) and the sticky o_tmo_err output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module scsi_io_arb
  import scsi_pkg::*;
#(
  parameter int DEVS = 2
`ifdef SCSI_ARB_TMO_EN
  , parameter logic [31:0] TMO_CYCLES = 32'd50_000_000
`endif
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [32*DEVS-1:0]   i_tgt_lba,
  input  logic [DEVS-1:0]      i_tgt_rd,
  input  logic [DEVS-1:0]      i_tgt_wr,
  output logic [DEVS-1:0]      o_tgt_ack,
  input  logic [16*DEVS-1:0]   i_tgt_buff_din,
  output logic [DEVS-1:0]      o_tgt_buff_wr,
  output logic [31:0]          o_io_lba,
  output logic                 o_io_rd,
  output logic                 o_io_wr,
  input  logic                 i_io_ack,
  output logic [DEV_IDX_W-1:0] o_io_dev,
  input  logic                 i_sd_buff_wr,
  output logic [15:0]          o_sd_buff_din,
`ifdef SCSI_ARB_TMO_EN
  output logic                 o_tmo_err,
`endif
  output logic                 o_busy
);

  state_t               r_state;
  logic [DEV_IDX_W-1:0] r_ptr;
  logic [DEV_IDX_W-1:0] r_gnt;
  logic [DEVS-1:0]      r_tgt_ack;
  logic [31:0]          r_io_lba;
  logic                 r_io_rd;
  logic                 r_io_wr;
  logic [DEV_IDX_W-1:0] r_io_dev;
  logic                 r_busy;

  logic [DEV_IDX_W-1:0] w_pick_idx;
  logic                 w_pick_valid;
  logic [31:0]          w_pick_lba;
  logic                 w_pick_rd;
  op_t                  w_pick_op;
  logic [DEVS-1:0]      w_gnt_oh;
  logic [15:0]          w_gnt_din;
  logic                 w_tmo;

`ifdef SCSI_ARB_TMO_EN
  logic [31:0]          r_tmo_cnt;
  logic                 r_tmo_err;
`endif

  scsi_rr_pick #(
    .DEVS (DEVS)
  ) u_pick (
    .i_req   (i_tgt_rd | i_tgt_wr),
    .i_ptr   (r_ptr),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  // Select the candidate's LBA/op and decode the current grant.
  always_comb begin
    w_pick_lba = '0;
    w_pick_rd  = 1'b0;
    w_gnt_oh   = '0;
    w_gnt_din  = '0;
    for (int i = 0; i < DEVS; i++) begin
      if (w_pick_idx == DEV_IDX_W'(i)) begin
        w_pick_lba = i_tgt_lba[32*i +: 32];
        w_pick_rd  = i_tgt_rd[i];
      end
      if (r_gnt == DEV_IDX_W'(i)) begin
        w_gnt_oh[i] = 1'b1;
        w_gnt_din   = i_tgt_buff_din[16*i +: 16];
      end
    end
  end

  // Read wins when a target raises rd and wr together.
  assign w_pick_op = w_pick_rd ? OP_RD : OP_WR;

`ifdef SCSI_ARB_TMO_EN
  assign w_tmo = ((r_state == REQ) || (r_state == XFER)) &&
                 (r_tmo_cnt == TMO_CYCLES - 32'd1);
`else
  assign w_tmo = 1'b0;
`endif

  // Arbitration / handshake sequencer with registered host-side outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_gnt     <= '0;
      r_tgt_ack <= '0;
      r_io_lba  <= '0;
      r_io_rd   <= 1'b0;
      r_io_wr   <= 1'b0;
      r_io_dev  <= '0;
      r_busy    <= 1'b0;
`ifdef SCSI_ARB_TMO_EN
      r_tmo_cnt <= '0;
      r_tmo_err <= 1'b0;
`endif
    end else begin
`ifdef SCSI_ARB_TMO_EN
      r_tmo_cnt <= r_tmo_cnt + 32'd1;
`endif
      case (r_state)
        IDLE: begin
          r_tgt_ack <= '0;
          if (w_pick_valid) begin
            r_gnt    <= w_pick_idx;
            r_io_dev <= w_pick_idx;
            r_io_lba <= w_pick_lba;
            r_io_rd  <= (w_pick_op == OP_RD);
            r_io_wr  <= (w_pick_op == OP_WR);
            r_busy   <= 1'b1;
            r_state  <= REQ;
`ifdef SCSI_ARB_TMO_EN
            r_tmo_cnt <= '0;
`endif
          end
        end
        REQ: begin
          if (w_tmo) begin
            r_io_rd   <= 1'b0;
            r_io_wr   <= 1'b0;
            r_tgt_ack <= w_gnt_oh;
            r_busy    <= 1'b0;
            r_state   <= DONE;
`ifdef SCSI_ARB_TMO_EN
            r_tmo_err <= 1'b1;
`endif
          end else if (i_io_ack) begin
            r_io_rd   <= 1'b0;
            r_io_wr   <= 1'b0;
            r_tgt_ack <= w_gnt_oh;
            r_state   <= XFER;
`ifdef SCSI_ARB_TMO_EN
            r_tmo_cnt <= '0;
`endif
          end
        end
        XFER: begin
          if (w_tmo) begin
            r_tgt_ack <= w_gnt_oh;
            r_busy    <= 1'b0;
            r_state   <= DONE;
`ifdef SCSI_ARB_TMO_EN
            r_tmo_err <= 1'b1;
`endif
          end else if (i_io_ack) begin
            r_tgt_ack <= w_gnt_oh;
          end else begin
            r_tgt_ack <= '0;
            r_busy    <= 1'b0;
            r_state   <= DONE;
          end
        end
        DONE: begin
          r_tgt_ack <= '0;
          r_busy    <= 1'b0;
          r_ptr     <= (r_gnt == DEV_IDX_W'(DEVS - 1)) ? '0 : r_gnt + 1'b1;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_tgt_ack     = r_tgt_ack;
  assign o_io_lba      = r_io_lba;
  assign o_io_rd       = r_io_rd;
  assign o_io_wr       = r_io_wr;
  assign o_io_dev      = r_io_dev;
  assign o_busy        = r_busy;
  assign o_sd_buff_din = r_busy ? w_gnt_din : 16'h0000;
  // Host strobes reach only the granted target, and only while io_ack is up.
  assign o_tgt_buff_wr = ((r_state == REQ) || (r_state == XFER)) ?
                         (w_gnt_oh & {DEVS{i_sd_buff_wr & i_io_ack}}) : '0;
`ifdef SCSI_ARB_TMO_EN
  assign o_tmo_err     = r_tmo_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_scsi_io_arb.sv
// ============================================================================
// Module   : tb_scsi_io_arb
// Brief    : Directed self-checking bench for scsi_io_arb (DEVS=2).
//            With SCSI_ARB_TMO_EN defined the watchdog path is also exercised.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scsi_io_arb;

  localparam int DEVS = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [32*DEVS-1:0] tgt_lba = '0;
  logic [DEVS-1:0]   tgt_rd = '0;
  logic [DEVS-1:0]   tgt_wr = '0;
  logic [DEVS-1:0]   tgt_ack;
  logic [16*DEVS-1:0] tgt_buff_din = '0;
  logic [DEVS-1:0]   tgt_buff_wr;
  logic [31:0]       io_lba;
  logic              io_rd;
  logic              io_wr;
  logic              io_ack = 1'b0;
  logic [2:0]        io_dev;
  logic              sd_buff_wr = 1'b0;
  logic [15:0]       sd_buff_din;
  logic              busy;
`ifdef SCSI_ARB_TMO_EN
  logic              tmo_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  scsi_io_arb #(
    .DEVS       (DEVS)
`ifdef SCSI_ARB_TMO_EN
    , .TMO_CYCLES (32'd16)
`endif
  ) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_tgt_lba      (tgt_lba),
    .i_tgt_rd       (tgt_rd),
    .i_tgt_wr       (tgt_wr),
    .o_tgt_ack      (tgt_ack),
    .i_tgt_buff_din (tgt_buff_din),
    .o_tgt_buff_wr  (tgt_buff_wr),
    .o_io_lba       (io_lba),
    .o_io_rd        (io_rd),
    .o_io_wr        (io_wr),
    .i_io_ack       (io_ack),
    .o_io_dev       (io_dev),
    .i_sd_buff_wr   (sd_buff_wr),
    .o_sd_buff_din  (sd_buff_din),
`ifdef SCSI_ARB_TMO_EN
    .o_tmo_err      (tmo_err),
`endif
    .o_busy         (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Complete an already-granted transfer: ack for n cycles, target drops
  // its request once acked, then step through DONE back to IDLE.
  task automatic xfer(input int dev, input int n);
    io_ack = 1'b1;
    tick();
    tgt_rd[dev] = 1'b0;
    tgt_wr[dev] = 1'b0;
    repeat (n - 1) tick();
    io_ack = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    // ---------------- reset state ----------------
    tick();
    tick();
    chk("rst_busy",  32'(busy), 32'h0);
    chk("rst_io_rd", 32'(io_rd), 32'h0);
    chk("rst_io_wr", 32'(io_wr), 32'h0);
    chk("rst_lba",   io_lba, 32'h0);
    chk("rst_ack",   32'(tgt_ack), 32'h0);
    chk("rst_din",   32'(sd_buff_din), 32'h0);
`ifdef SCSI_ARB_TMO_EN
    chk("rst_tmo",   32'(tmo_err), 32'h0);
`endif
    reset = 1'b0;
    tick();

    // ---------------- single read, target 0 ----------------
    tgt_lba[31:0] = 32'h100;
    tgt_rd[0] = 1'b1;
    tick();
    chk("t1_io_rd",  32'(io_rd), 32'h1);
    chk("t1_io_wr",  32'(io_wr), 32'h0);
    chk("t1_lba",    io_lba, 32'h100);
    chk("t1_dev",    32'(io_dev), 32'h0);
    chk("t1_busy",   32'(busy), 32'h1);
    chk("t1_ack_pre", 32'(tgt_ack), 32'h0);
    io_ack = 1'b1;
    tick();
    chk("t1_rd_drop", 32'(io_rd), 32'h0);
    chk("t1_ack_c1", 32'(tgt_ack), 32'h1);
    tgt_rd[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t1_ack_cN", 32'(tgt_ack), 32'h1);
    end
    io_ack = 1'b0;
    tick();
    chk("t1_ack_end", 32'(tgt_ack), 32'h0);
    chk("t1_busy_done", 32'(busy), 32'h0);
    tick();
    chk("t1_idle_rd", 32'(io_rd), 32'h0);

    // ---------------- io_ack while idle is ignored ----------------
    io_ack = 1'b1;
    tick();
    tick();
    chk("idle_ack", 32'(tgt_ack), 32'h0);
    chk("idle_busy", 32'(busy), 32'h0);
    io_ack = 1'b0;

    // ---------------- both targets, ptr=0 ----------------
    reset = 1'b1;
    #1;
    reset = 1'b0;
    tick();
    tgt_lba = {32'h11, 32'h10};
    tgt_rd  = 2'b11;
    tick();
    chk("rr_first_dev", 32'(io_dev), 32'h0);
    chk("rr_first_lba", io_lba, 32'h10);
    xfer(0, 2);
    tick();
    chk("rr_second_dev", 32'(io_dev), 32'h1);
    chk("rr_second_lba", io_lba, 32'h11);
    chk("rr_second_rd",  32'(io_rd), 32'h1);
    io_ack = 1'b1;
    tick();
    chk("rr_ack1", 32'(tgt_ack), 32'h2);
    tgt_rd[1] = 1'b0;
    tgt_lba[31:0] = 32'h20;
    tgt_rd[0] = 1'b1;
    tick();
    chk("rr_wait_dev", 32'(io_dev), 32'h1);
    chk("rr_wait_ack", 32'(tgt_ack), 32'h2);
    io_ack = 1'b0;
    tick();
    tick();
    tick();
    chk("rr_third_dev", 32'(io_dev), 32'h0);
    chk("rr_third_lba", io_lba, 32'h20);
    xfer(0, 1);

    // ---------------- target 1 write with buffer strobes ----------------
    tgt_buff_din = {16'hA55A, 16'h1234};
    tgt_lba[63:32] = 32'h300;
    tgt_wr[1] = 1'b1;
    tick();
    chk("wr_io_wr",  32'(io_wr), 32'h1);
    chk("wr_io_rd",  32'(io_rd), 32'h0);
    chk("wr_dev",    32'(io_dev), 32'h1);
    chk("wr_din",    32'(sd_buff_din), 32'hA55A);
    io_ack = 1'b1;
    tick();
    tgt_wr[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      sd_buff_wr = 1'b1;
      #1;
      chk("wr_strobe_hi", 32'(tgt_buff_wr), 32'h2);
      sd_buff_wr = 1'b0;
      #1;
      chk("wr_strobe_lo", 32'(tgt_buff_wr), 32'h0);
      tick();
    end
    io_ack = 1'b0;
    tick();
    tick();
    chk("wr_din_idle", 32'(sd_buff_din), 32'h0);

    // ---------------- rd+wr together, LBA committed ----------------
    tgt_lba[31:0] = 32'h100;
    tgt_rd[0] = 1'b1;
    tgt_wr[0] = 1'b1;
    tick();
    chk("both_io_rd", 32'(io_rd), 32'h1);
    chk("both_io_wr", 32'(io_wr), 32'h0);
    tgt_lba[31:0] = 32'h200;
    tgt_wr[0] = 1'b0;
    tick();
    chk("commit_lba", io_lba, 32'h100);
    chk("commit_rd",  32'(io_rd), 32'h1);
    io_ack = 1'b1;
    tick();
    chk("commit_ack", 32'(tgt_ack), 32'h1);
    tgt_rd[0] = 1'b0;
    tick();

    // ---------------- reset during XFER ----------------
    reset = 1'b1;
    #1;
    chk("mid_rst_ack",  32'(tgt_ack), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_lba",  io_lba, 32'h0);
    chk("mid_rst_din",  32'(sd_buff_din), 32'h0);
    reset = 1'b0;
    tick();
    tick();
    chk("post_rst_ack",  32'(tgt_ack), 32'h0);
    chk("post_rst_busy", 32'(busy), 32'h0);
    io_ack = 1'b0;
    tgt_lba = {32'h44, 32'h33};
    tgt_rd = 2'b11;
    tick();
    chk("post_rst_ptr", 32'(io_dev), 32'h0);
    xfer(0, 1);
    tick();
    chk("post_rst_next", 32'(io_dev), 32'h1);
    xfer(1, 1);

`ifdef SCSI_ARB_TMO_EN
    // ---------------- watchdog ----------------
    tgt_lba[63:32] = 32'h500;
    tgt_rd[1] = 1'b1;
    tick();
    chk("tmo_rd_on", 32'(io_rd), 32'h1);
    repeat (15) tick();
    chk("tmo_rd_15", 32'(io_rd), 32'h1);
    chk("tmo_err_pre", 32'(tmo_err), 32'h0);
    tick();
    chk("tmo_rd_drop", 32'(io_rd), 32'h0);
    chk("tmo_pulse",   32'(tgt_ack), 32'h2);
    chk("tmo_err_set", 32'(tmo_err), 32'h1);
    tgt_rd[1] = 1'b0;
    tick();
    chk("tmo_pulse_end", 32'(tgt_ack), 32'h0);
    tick();
    chk("tmo_idle_busy", 32'(busy), 32'h0);
    chk("tmo_sticky", 32'(tmo_err), 32'h1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/scsi_io_arb.md
Name: scsi_io_arb

Overview:
- Shares the single MiSTer io-controller sector port (lba/rd/wr/ack plus sd_buff) between DEVS SCSI target instances behind the ncr5380 block.
- Targets raise independent block read/write requests. The arbiter grants one at a time, round-robin, and forwards the transfer to the host port.
- Steers ack, sd_buff_wr and sd_buff_din for the granted target only; releases the grant when the host handshake completes.
- Sits between the per-target scsi instances and the top-level io-controller ports.

Parameters:
- DEVS, 2, number of SCSI targets sharing the port (1..8)
- TMO_CYCLES, 32'd50_000_000, watchdog limit in clk cycles (used only with SCSI_ARB_TMO_EN)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- tgt_lba  in  32 x DEVS  per-target requested LBA
- tgt_rd  in  DEVS  per-target read request (level, held until tgt_ack)
- tgt_wr  in  DEVS  per-target write request (level, held until tgt_ack)
- tgt_ack  out  DEVS  per-target ack, one-hot or zero
- tgt_buff_din  in  16 x DEVS  per-target write data toward host
- tgt_buff_wr  out  DEVS  per-target sd_buff write strobe
- io_lba  out  32  LBA to io controller
- io_rd  out  1  read request to io controller
- io_wr  out  1  write request to io controller
- io_ack  in  1  io controller acknowledge (high for the whole transfer)
- io_dev  out  3  index of granted target
- sd_buff_wr  in  1  host buffer write strobe
- sd_buff_din  out  16  muxed write data to host
- busy  out  1  grant active

Behaviour:
- Reset (async, immediate):
  - tgt_ack=0, tgt_buff_wr=0, io_rd=0, io_wr=0, io_lba=0, io_dev=0, sd_buff_din=0 (combinational mux of a non-granted state), busy=0.
  - Round-robin pointer=0; state=IDLE.
  - Reset mid-transfer abandons the grant with no completion.
- IDLE:
  - Pending set is tgt_rd|tgt_wr.
  - If any request is pending, pick the first pending index at or after ptr, modulo DEVS.
  - Latch gnt=idx, io_lba=tgt_lba[idx], io_dev=idx, and the operation: rd wins when both rd and wr are high. Go to REQ with busy=1.
  - Decision is registered: 1 cycle from request to io_rd/io_wr asserted.
- REQ:
  - io_rd or io_wr held high until io_ack seen high; then drop io_rd/io_wr and go to XFER.
  - Changes to tgt_lba or the request bits after the grant are ignored: LBA and op are committed.
- XFER:
  - tgt_ack[gnt] = io_ack (registered, 1-cycle delay).
  - tgt_buff_wr[gnt] = sd_buff_wr & io_ack.
  - sd_buff_din = tgt_buff_din[gnt] combinationally while busy, else 0.
  - On io_ack falling, go to DONE.
- DONE:
  - One cycle: tgt_ack=0, busy=0, ptr=(gnt+1) mod DEVS, then IDLE.
  - A target still holding its request after DONE is re-arbitrated normally and gets no priority.
- Boundary conditions:
  - io_ack high while IDLE: ignored, no tgt_ack.
  - Simultaneous requests from all targets: served in ptr order, each exactly once per round.
  - DEVS=1: ptr stays 0.
  - Non-granted targets always see tgt_ack=0 and tgt_buff_wr=0.
  - Neither io_rd nor io_wr is ever high in IDLE or DONE; never both high together.

Optional Feature:
- SCSI_ARB_TMO_EN defined:
  - A 32-bit counter runs in REQ and XFER and clears on each state entry.
  - Reaching TMO_CYCLES forces io_rd=io_wr=0 and pulses tgt_ack[gnt] high for 1 cycle, so the target does not hang.
  - Then DONE, with sticky output tmo_err (extra port, 1 bit, reset 0, cleared by reset only).
- Undefined: no counter and no tmo_err port; the arbiter waits on io_ack indefinitely.

Decomposition:
- Package scsi_pkg:
  - state enum (IDLE, REQ, XFER, DONE)
  - DEV_IDX_W=3 constant
  - op typedef (OP_RD, OP_WR)
- Sub-module scsi_rr_pick: combinational round-robin first-set picker (req vector, ptr -> idx, valid), parameterised by DEVS.

Test Plan:
- Target 0 raises tgt_rd with lba=0x100 -> next cycle io_rd=1, io_lba=0x100, io_dev=0. Then io_ack high 4 cycles -> tgt_ack[0] high 4 cycles delayed by 1, io_rd low after first ack cycle.
- Both targets raise rd in the same cycle with ptr=0 -> target 0 served first, then target 1. A third request from target 0 during target 1's transfer waits until DONE.
- Target 1 write with sd_buff_wr pulses during io_ack -> tgt_buff_wr[1] mirrors the pulses. sd_buff_din equals tgt_buff_din[1] (e.g. 0xA55A); tgt_buff_wr[0]=0 throughout.
- Target raises rd and wr together -> only io_rd asserted; tgt_lba changed to 0x200 after grant -> io_lba stays 0x100.
- Assert reset while in XFER -> all outputs 0 immediately, ptr=0. A later io_ack is ignored until a new request.
- With SCSI_ARB_TMO_EN and TMO_CYCLES=16, no io_ack -> io_rd drops at cycle 16, single-cycle tgt_ack pulse, tmo_err=1, arbiter returns to IDLE.
